serial_addsub: RTL
==================

# serial_addsub

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, with a carry register between digits. It generalises the team's 4-bit ripple full adder in three ways: operand width is parametrised, subtraction is selectable, and a start/busy/done handshake is added. It serves as the datapath arithmetic unit wherever area matters more than latency.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; NDIG = WIDTH/DIGIT cycles per operation.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in (add) or borrow-in (subtract); captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add) or borrow-out (subtract).
- ovf  output  1  two's-complement signed overflow.

## Operation
- **Add:** {cout,sum} = a + b + cin.
- **Subtract:** sum = a − b − cin (mod 2^WIDTH). Computed internally as a + ~b + ~cin. cout = inverted internal carry, i.e. 1 when a < b + cin (unsigned).
- **ovf:** 1 when the MSBs of a and of the effective b (b or ~b) are equal and the MSB of sum differs from them.
- **State machine:** IDLE, RUN, DONE.
  - IDLE: start=1 → latch a, effective b, sub and internal carry (cin ^ sub); clear digit index; go to RUN.
  - RUN: each cycle, add digit[idx] of A, digit[idx] of effective B and the carry register. Write the digit into the sum shift register and update the carry. After digit NDIG−1, go to DONE.
  - DONE: done=1. start=1 → capture new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- start during RUN is ignored. Operand inputs are don't-care except in the capture cycle.
- sum, cout and ovf hold their last values until the final digit of the next operation. No partial result is ever visible on the outputs.
- **Reset:** busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE. Reset mid-RUN aborts the operation with no done pulse.

## Timing
- Edge E0 samples start. Edges E1..ENDIG process digits 0..NDIG−1.
- sum, cout and ovf update at ENDIG. done is high in the cycle following ENDIG.
- Start-to-done latency is NDIG+1 edges: 5 for WIDTH=16, DIGIT=4; 2 for DIGIT=WIDTH.
- busy is high from E0 until ENDIG, low in DONE and IDLE.
- Back-to-back throughput is one result per NDIG+1 cycles.
- Combinational path per cycle is one DIGIT-bit adder plus carry; no input-to-output combinational path.

## Structure
- Shared package arith_pkg holds:
  - state enum {S_IDLE, S_RUN, S_DONE}
  - the NDIG computation
  - an elaboration-time check that WIDTH % DIGIT == 0
- Sub-module addsub_digit: combinational DIGIT-bit ripple adder with carry-in, carry-out and MSB carry-in (for ovf). It is instantiated once and reused every cycle.
- Top level holds the FSM, operand shift registers, carry register, digit counter ($clog2(NDIG)+1 bits) and output registers.

## Test plan
Directed scenarios at WIDTH=16, DIGIT=4 unless stated:
- **Basic add:** add a=0x0042, b=0x0021, cin=1 → sum=0x0064, cout=0, ovf=0; done exactly 5 cycles after start.
- **Carry out:** add a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0.
- **Positive overflow:** add a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- **Subtract with borrow:** sub a=0x0000, b=0x0001, cin=0 → sum=0xFFFF, cout(borrow)=1, ovf=0. Then sub a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1, cout=0.
- **Handshake:**
  - start pulsed again during RUN → ignored; result matches the first operands.
  - start in DONE → second result arrives 5 cycles later, with no idle cycle between.
- **Reset and degenerate width:**
  - rst_n asserted at the second RUN cycle → all outputs 0 immediately and no done pulse; the next start completes normally.
  - Repeat the basic add with DIGIT=16 → latency 2.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state type and digit-split helpers for the serial add/subtract datapath
package arith_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  function automatic int ndig(input int w, input int d);
    return w / d;
  endfunction
  function automatic bit split_ok(input int w, input int d);
    return d > 0 && w % d == 0;
  endfunction
endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand/result bus with start/busy/done handshake
interface serial_addsub_if #(parameter int WIDTH = 16);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit adder with carry-out and the carry into its MSB
module addsub_digit #(parameter int DIGIT = 4) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o,
  output logic             cmsb_o
);
  assign {c_o, s_o} = (DIGIT+1)'(a_i) + (DIGIT+1)'(b_i) + (DIGIT+1)'(c_i);
  // carry into the MSB recovered from the MSB sum bit
  assign cmsb_o = s_o[DIGIT-1] ^ a_i[DIGIT-1] ^ b_i[DIGIT-1];
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial add/subtract, DIGIT bits per cycle LSB first, start/busy/done handshake
module serial_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic rst_n,
  serial_addsub_if.slave bus
);
  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int IW   = $clog2(NDIG) + 1;
  if (!split_ok(WIDTH, DIGIT)) begin : g_bad_split
    $error("serial_addsub: WIDTH must be a multiple of DIGIT");
  end
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q, acc_d;
  logic [IW-1:0]    idx_q;
  logic             sub_q, carry_q, cout_q, ovf_q, busy_q, done_q;
  logic [DIGIT-1:0] s;
  logic             co, cm;
  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i(a_q[DIGIT-1:0]), .b_i(b_q[DIGIT-1:0]), .c_i(carry_q),
    .s_o(s), .c_o(co), .cmsb_o(cm)
  );
  // new digit enters at the top; after NDIG shifts digit 0 sits at the LSB
  assign acc_d = WIDTH'({s, acc_q} >> DIGIT);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            sub_q   <= bus.sub;
            carry_q <= bus.cin ^ bus.sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_d;
          carry_q <= co;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == IW'(NDIG - 1)) begin
            sum_q   <= acc_d;
            cout_q  <= co ^ sub_q;
            ovf_q   <= co ^ cm;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule
